// File: rtl/ifetch.sv
// ============================================================================
// Module   : ifetch
// Purpose  : Instruction fetch stage: sequential PC generation, credit-limited
//            imem requests, in-order response FIFO and redirect flushing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      rsp_pc_q,   rsp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q,     drop_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;

    logic [31:0] data_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic [SUM_W-1:0] w_occupancy;
    logic             w_credit_ok;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_lsb;

    // Every issued or pending response reserves a FIFO slot, so the FIFO cannot overflow.
    assign w_occupancy    = SUM_W'(inflight_q) + SUM_W'(drop_q) + SUM_W'(count_q);
    assign w_credit_ok    = w_occupancy < SUM_W'(DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_push         = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign w_pop          = (count_q != '0) && inst_ready;
    assign w_unused_lsb   = ^redirect_pc[1:0];

    assign inst_valid = (count_q != '0);
    assign inst       = data_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = '0;
            // A response landing this cycle retires one outstanding request, live or stale.
            drop_d     = drop_q + inflight_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (w_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            inflight_d = inflight_q + CNT_W'(w_req_fire) - CNT_W'(w_push);
            count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (w_push) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module   : tb_ifetch
// Purpose  : Directed self-checking bench for ifetch with a latency-configurable
//            in-order instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          n_acc   = 0;
    int          n_pop   = 0;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Memory model: returns data for the oldest accepted request once its latency elapses.
    task automatic drive_rsp();
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0] ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic step();
        #1;
        if (redirect_valid) check("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            n_acc++;
        end
        if (inst_valid && inst_ready) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_rsp();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_req = {target[31:2], 2'b00};
        exp_pc  = {target[31:2], 2'b00};
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int base_acc;
        int base_pop;
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        exp_req        = RPC;
        exp_pc         = RPC;
        #1 rst = 1'b1;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);

        // Sequential fetch, L=1
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RPC);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) check("lat_inst_valid", {31'b0, inst_valid}, (i >= 2) ? 32'd1 : 32'd0);
            step();
        end
        check("seq_pops", n_pop, 32'd10);

        // Back-pressure: decode stalls, fetch must stop at DEPTH
        inst_ready = 1'b0;
        base_acc = n_acc;
        do_redirect(32'h0000_0800);
        run(10);
        check("bp_accepts", n_acc - base_acc, 32'd4);
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        #1;
        check("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        #1;
        check("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
        run(8);

        // Redirect with three requests in flight, L=3
        imem_req_ready = 1'b0;
        run(6);
        imem_req_ready = 1'b1;
        lat = 3;
        do_redirect(32'h0000_1000);
        run(3);
        check("t3_inflight", dut.inflight_q, 32'd3);
        check("t3_rsp_now", {31'b0, imem_rsp_valid}, 32'd1);
        base_pop = n_pop;
        do_redirect(32'h0000_2002);
        check("t3_drop", dut.drop_q, 32'd2);
        check("t3_empty", {31'b0, inst_valid}, 32'd0);
        check("t3_next_addr", imem_req_addr, 32'h0000_2000);
        run(14);
        check("t3_pops", {31'b0, (n_pop - base_pop) >= 4}, 32'd1);

        // Redirect, response and pop in the same cycle, L=2 steady stream
        imem_req_ready = 1'b0;
        run(8);
        imem_req_ready = 1'b1;
        lat = 2;
        run(4);
        check("t4_pre_valid", {31'b0, inst_valid}, 32'd1);
        check("t4_pre_rsp", {31'b0, imem_rsp_valid}, 32'd1);
        check("t4_pre_inflight", dut.inflight_q, 32'd2);
        base_pop = n_pop;
        do_redirect(32'h0000_4000);
        check("t4_popped", n_pop - base_pop, 32'd1);
        check("t4_empty", {31'b0, inst_valid}, 32'd0);
        check("t4_drop", dut.drop_q, 32'd1);
        run(10);

        // Wrap-around at the top of the address space, L=1
        lat = 1;
        base_pop = n_pop;
        do_redirect(32'hFFFF_FFF8);
        run(10);
        check("wrap_pops", {31'b0, (n_pop - base_pop) >= 3}, 32'd1);

        // Asynchronous reset off a clock edge
        #2;
        rst = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1;
        check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("arst_req_addr", imem_req_addr, RPC);
        check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        exp_req = RPC;
        exp_pc  = RPC;
        #1;
        check("arst_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        check("arst_restart_addr", imem_req_addr, RPC);
        base_pop = n_pop;
        run(6);
        check("arst_pops", n_pop - base_pop, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
